// File: rtl/react_toggle_monitor.sv
// react_toggle_monitor: checks a device bit stream alternates on every active sample, locks, counts toggles and faults
module react_toggle_monitor #(
  parameter int LOCK_LEN = 4,
  parameter int MAX_ERR  = 3,
  parameter int CNT_W    = 8,
  parameter int ERR_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle_in,
  input  logic             cont_in,
  input  logic             clear_in,
  output logic             locked,
  output logic             fault,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);
  localparam int RW = $clog2(LOCK_LEN + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SYNC   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;
  localparam logic [RW:0] LOCK_V  = (RW + 1)'(LOCK_LEN);
  // MAX_ERR above the saturated err_cnt is a config error: threshold becomes unreachable
  localparam logic [ERR_W:0] MAX_E = (MAX_ERR > 2 ** ERR_W - 1) ? {(ERR_W + 1){1'b1}} : (ERR_W + 1)'(MAX_ERR);
  logic [1:0]       state;
  logic             prev_bit;
  logic [RW-1:0]    run;
  logic [RW:0]      run_nx;
  logic [ERR_W-1:0] err_inc;
  logic             good;
  logic             err_hit;
  always_comb begin
    good    = toggle_in != prev_bit;
    run_nx  = {1'b0, run} + 1'b1;
    err_inc = &err_cnt ? err_cnt : err_cnt + 1'b1;
    err_hit = {1'b0, err_inc} >= MAX_E;
  end
  assign locked = state == S_LOCKED;
  assign fault  = state == S_FAULT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      prev_bit   <= 1'b0;
      run        <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      toggle_cnt <= '0;
    end else if (clear_in) begin
      state      <= S_IDLE;
      run        <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      toggle_cnt <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (cont_in) begin
        prev_bit <= toggle_in;
        case (state)
          S_IDLE: begin
            state <= S_SYNC;
            run   <= '0;
          end
          S_SYNC: begin
            run   <= (good && run_nx != LOCK_V) ? run_nx[RW-1:0] : '0;
            state <= (good && run_nx == LOCK_V) ? S_LOCKED : S_SYNC;
          end
          S_LOCKED: begin
            if (good) toggle_cnt <= toggle_cnt + 1'b1;
            else begin
              err_pulse <= 1'b1;
              err_cnt   <= err_inc;
              run       <= '0;
              state     <= err_hit ? S_FAULT : S_SYNC;
            end
          end
          default: state <= S_FAULT;
        endcase
      end
    end
  end
endmodule
